// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle DIV/DIVU sequencer: state encoding,
// default width and the decode funct codes that select signed operation.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [5:0] FUNCT_DIV  = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU = 6'h1B;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CHK  = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } div_state_e;

  // Decode helper: DIV is two's complement, DIVU is unsigned.
  function automatic logic funct_is_signed(input logic [5:0] funct);
    return (funct == FUNCT_DIV);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift {R,Q} left by one, then
// subtract D from the partial remainder when it fits and set the quotient bit.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] r_in,
  input  logic [W-1:0] q_in,
  input  logic [W-1:0] d,
  output logic [W-1:0] r_out,
  output logic [W-1:0] q_out
);

  logic [W:0]   part;
  logic [W-1:0] diff;
  logic         fits;

  // The shifted partial remainder needs W+1 bits; after a successful subtract
  // it is below D again, so the low W bits of the difference are exact.
  assign part  = {r_in, q_in[W-1]};
  assign fits  = (part >= {1'b0, d});
  assign diff  = part[W-1:0] - d;
  assign r_out = fits ? diff : part[W-1:0];
  assign q_out = {q_in[W-2:0], fits};

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle restoring divider sequencer for DIV/DIVU. Quotient goes to LO,
// remainder to HI; the pipeline stalls while busy and commits on done.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output div_state_e       dbg_state
);

  // Handshake: start is accepted only in IDLE with flush low; busy rises the
  // next cycle and stays high through the single-cycle done pulse. Results
  // hold their value until the next op commits; a flushed op commits nothing.
  div_state_e       st;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd_orig;
  logic [WIDTH-1:0] dvs_abs;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] q_acc;
  logic             q_neg;
  logic             r_neg;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // Magnitudes; the most negative value maps onto itself, which the unsigned
  // datapath then treats as 2^(WIDTH-1), giving the wrap-around MIN/-1 result.
  assign dvd_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign dvs_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  div_step #(.W(WIDTH)) u_step (
    .r_in  (r_acc),
    .q_in  (q_acc),
    .d     (dvs_abs),
    .r_out (r_nxt),
    .q_out (q_nxt)
  );

  assign q_fix     = q_neg ? -q_acc : q_acc;
  assign r_fix     = r_neg ? -r_acc : r_acc;
  assign dbg_state = st;

  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= ST_IDLE;
      cnt         <= '0;
      dvd_orig    <= '0;
      dvs_abs     <= '0;
      r_acc       <= '0;
      q_acc       <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          done <= 1'b0;
          if (start && !flush) begin
            dvd_orig <= dividend;
            dvs_abs  <= dvs_mag;
            r_acc    <= '0;
            q_acc    <= dvd_mag;
            q_neg    <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg    <= is_signed & dividend[WIDTH-1];
            cnt      <= '0;
            busy     <= 1'b1;
            st       <= ST_CHK;
          end
        end
        ST_CHK: begin
          if (flush) begin
            busy <= 1'b0;
            st   <= ST_IDLE;
          end else if (dvs_abs == '0) begin
            quotient    <= '1;
            remainder   <= dvd_orig;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            st          <= ST_DONE;
          end else begin
            st <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (flush) begin
            busy <= 1'b0;
            cnt  <= '0;
            st   <= ST_IDLE;
          end else begin
            r_acc <= r_nxt;
            q_acc <= q_nxt;
            if (cnt == CNT_W'(WIDTH - 1)) begin
              cnt <= '0;
              st  <= ST_FIX;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_FIX: begin
          if (flush) begin
            busy <= 1'b0;
            st   <= ST_IDLE;
          end else begin
            quotient    <= q_fix;
            remainder   <= r_fix;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            st          <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Result already committed; flush here cannot cancel the pulse.
          done <= 1'b0;
          busy <= 1'b0;
          st   <= ST_IDLE;
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
          st   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: hand-computed DIV/DIVU results, latency,
// divide-by-zero, flush abort, ignored start while busy and mid-op reset.
module tb_div_seq_ctrl;
  import div_pkg::*;

  localparam int W     = 32;
  localparam int LAT   = 35;
  localparam int LAT_Z = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         flush;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  div_state_e   dbg_state;

  int vectors     = 0;
  int miscompares = 0;

  div_seq_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a start for one edge; returns #1 after the accepting edge.
  task automatic start_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start     = 1'b1;
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1;
    start     = 1'b0;
    is_signed = $urandom_range(0, 1);
    dividend  = $urandom;
    divisor   = $urandom;
  endtask

  // Cycle 1 is the cycle right after the accepting edge.
  task automatic run_op(input string tag, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eq,
                        input logic [W-1:0] er, input logic ez, input int ecyc);
    int cyc;
    start_op(sgn, a, b);
    chk({tag, "_busy1"}, W'(busy), W'(1));
    cyc = 1;
    while (!done && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "_done_seen"}, W'(done), W'(1));
    chk({tag, "_latency"}, W'(cyc), W'(ecyc));
    chk({tag, "_busy_at_done"}, W'(busy), W'(1));
    chk({tag, "_quot"}, quotient, eq);
    chk({tag, "_rem"}, remainder, er);
    chk({tag, "_dz"}, W'(div_by_zero), W'(ez));
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, W'(done), W'(0));
    chk({tag, "_busy_after"}, W'(busy), W'(0));
    chk({tag, "_quot_hold"}, quotient, eq);
  endtask

  initial begin : main
    int pulses;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0;
    dividend = '0; divisor = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_quot", quotient, '0);
    chk("rst_rem", remainder, '0);
    chk("rst_dz", W'(div_by_zero), W'(0));
    chk("rst_state", W'(dbg_state), W'(ST_IDLE));

    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, LAT);
    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, LAT);
    run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, LAT);
    run_op("divu_min_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, LAT);
    run_op("divu_by0", 1'b0, 32'h1234, 32'h0, 32'hFFFF_FFFF, 32'h1234, 1'b1, LAT_Z);
    run_op("div_m1_by0", 1'b1, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, LAT_Z);
    run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, LAT);

    // Flush during RUN iteration 10: abort, outputs keep the 7/-2 results.
    start_op(1'b0, 32'd1000, 32'd3);
    repeat (11) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy", W'(busy), W'(0));
    chk("flush_state", W'(dbg_state), W'(ST_IDLE));
    chk("flush_quot", quotient, 32'hFFFF_FFFD);
    chk("flush_rem", remainder, 32'd1);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    chk("flush_no_done", W'(pulses), W'(0));
    run_op("after_flush", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, LAT);

    // Start and flush together in IDLE must not be accepted.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    chk("start_flush_busy", W'(busy), W'(0));

    // Second start while busy is ignored: exactly one done with the first result.
    start_op(1'b0, 32'hFFFF_FFFF, 32'h10);
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 45; i++) begin
      if (done) begin
        pulses++;
        chk("busy_start_quot", quotient, 32'h0FFF_FFFF);
        chk("busy_start_rem", remainder, 32'hF);
      end
      @(posedge clk);
      #1;
    end
    chk("busy_start_pulses", W'(pulses), W'(1));

    // Reset at RUN iteration 20 clears everything on the next edge.
    start_op(1'b1, 32'hFFFF_FF00, 32'd7);
    repeat (21) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midrst_busy", W'(busy), W'(0));
    chk("midrst_done", W'(done), W'(0));
    chk("midrst_quot", quotient, '0);
    chk("midrst_rem", remainder, '0);
    chk("midrst_dz", W'(div_by_zero), W'(0));
    chk("midrst_state", W'(dbg_state), W'(ST_IDLE));

    run_op("after_rst", 1'b1, 32'hFFFF_FF00, 32'd7, 32'hFFFF_FFDC, 32'hFFFF_FFFC, 1'b0, LAT);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
